// File: rtl/rv_multicycle_seq.sv
// Multi-cycle sequencer for the RISC-V core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB using req/ack handshakes so that
// instruction and data memories may insert wait states. Owns the PC, the instruction register,
// the load-data latch and the retire counter. A handshake that waits too long parks the core in
// TRAP with a sticky bus error.
module rv_multicycle_seq #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     TIMEOUT  = 15,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    // Instruction memory
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    // Decode interface
    output logic [31:0]      ir,
    input  logic             op_load,
    input  logic             op_store,
    input  logic             op_illegal,
    input  logic             wreg,
    // Datapath
    input  logic [XLEN-1:0]  next_pc,
    // Data memory
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [XLEN-1:0]  load_data,
    // Writeback / status
    output logic             reg_we,
    output logic [XLEN-1:0]  pc,
    output logic [CNT_W-1:0] instret,
    output logic             bus_err,
    output logic             halted,
    output logic [2:0]       state
);

    // Wide enough to hold TIMEOUT itself; one bit when the timeout is disabled.
    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [31:0]        ir_q, ir_d;
    logic [XLEN-1:0]    load_q, load_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               bus_err_q, bus_err_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               wait_expired;

    // The cycle in which the counter equals TIMEOUT is the last one an ack can still rescue.
    assign wait_expired = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT));

    // Next-state and register updates; every register holds unless its state says otherwise.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        load_d    = load_q;
        instret_d = instret_q;
        bus_err_d = bus_err_q;
        wait_d    = wait_q;

        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end else if (wait_expired) begin
                    // pc and ir are left untouched so the faulting fetch can be inspected.
                    bus_err_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StDecode: begin
                state_d = op_illegal ? StTrap : StExec;
            end
            StExec: begin
                if (op_load || op_store) begin
                    wait_d  = '0;
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    if (op_load) begin
                        load_d = dmem_rdata;
                    end
                    state_d = StWb;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StWb: begin
                pc_d      = next_pc;
                instret_d = instret_q + CNT_W'(1);
                wait_d    = '0;
                state_d   = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                // Unreachable encodings park the core rather than running on.
                state_d = StTrap;
            end
        endcase
    end

    // State and architectural registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            load_q    <= '0;
            instret_q <= '0;
            bus_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            load_q    <= load_d;
            instret_q <= instret_d;
            bus_err_q <= bus_err_d;
            wait_q    <= wait_d;
        end
    end

    // Strobes decoded from state; imem_req is gated by rst so an abandoned fetch drops at once.
    always_comb begin
        imem_req = (state_q == StFetch) && !rst;
        dmem_req = (state_q == StMem);
        dmem_we  = (state_q == StMem) && op_store;
        reg_we   = (state_q == StWb) && wreg;
        halted   = (state_q == StTrap);
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign load_data = load_q;
    assign instret   = instret_q;
    assign bus_err   = bus_err_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rv_multicycle_seq.sv
// Directed bench for rv_multicycle_seq: the bench plays decode unit, datapath and both memories.
module tb_rv_multicycle_seq;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        op_load;
    logic        op_store;
    logic        op_illegal;
    logic        wreg;
    logic [31:0] next_pc;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        reg_we;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        bus_err;
    logic        halted;
    logic [2:0]  state;

    int pass_cnt = 0;
    int total_cnt = 0;

    rv_multicycle_seq #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100),
        .TIMEOUT  (15),
        .CNT_W    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .op_load    (op_load),
        .op_store   (op_store),
        .op_illegal (op_illegal),
        .wreg       (wreg),
        .next_pc    (next_pc),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .load_data  (load_data),
        .reg_we     (reg_we),
        .pc         (pc),
        .instret    (instret),
        .bus_err    (bus_err),
        .halted     (halted),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        op_load    = 1'b0;
        op_store   = 1'b0;
        op_illegal = 1'b0;
        wreg       = 1'b0;
        next_pc    = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    // Reset pulse; returns 1 ns after a rising edge with the core in FETCH.
    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs one instruction from FETCH until it returns to FETCH after WB or lands in TRAP.
    // iwait/dwait: wait cycles before the memory acks.
    task automatic exec_instr(input logic [31:0] instr, input logic ld, input logic st,
                              input logic ill, input logic wr, input logic [31:0] npc,
                              input int iwait, input int dwait, input logic [31:0] drd,
                              output int cyc, output logic saw_reg_we, output logic saw_dwe,
                              output logic wb_reg_we, output logic [31:0] wb_ld,
                              output logic stuck);
        logic [2:0] cur;
        int wcnt;
        logic done;
        cyc = 0; wcnt = 0; done = 1'b0; stuck = 1'b1;
        saw_reg_we = 1'b0; saw_dwe = 1'b0; wb_reg_we = 1'b0; wb_ld = 32'h0;
        op_load = ld; op_store = st; op_illegal = ill; wreg = wr; next_pc = npc;
        imem_rdata = instr; dmem_rdata = drd;
        for (int k = 0; k < 200 && !done; k++) begin
            cur = state;
            imem_ack = (cur == 3'd0) && (wcnt == iwait);
            dmem_ack = (cur == 3'd3) && (wcnt == dwait);
            #2;
            if (reg_we) saw_reg_we = 1'b1;
            if (dmem_req && dmem_we) saw_dwe = 1'b1;
            if (cur == 3'd4) begin
                wb_reg_we = reg_we;
                wb_ld     = load_data;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (state != cur) wcnt = 0;
            else wcnt++;
            if ((cur == 3'd4 && state == 3'd0) || state == 3'd5) begin
                done  = 1'b1;
                stuck = 1'b0;
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1;
        clear_inputs();
        #2;
        total_cnt++;
        if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state);
        else pass_cnt++;
        total_cnt++;
        if (pc !== 32'h100) $display("FAIL reset_pc: got %h want 00000100", pc);
        else pass_cnt++;
        total_cnt++;
        if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %b want 0", imem_req);
        else pass_cnt++;
        total_cnt++;
        if (ir !== 32'h13) $display("FAIL reset_ir: got %h want 00000013", ir);
        else pass_cnt++;
        total_cnt++;
        if ({instret, load_data, bus_err, halted, reg_we, dmem_req, dmem_we} !== 69'h0)
            $display("FAIL reset_misc: instret %h load %h err %b halt %b rwe %b dreq %b dwe %b",
                     instret, load_data, bus_err, halted, reg_we, dmem_req, dmem_we);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL release_fetch: req %b addr %h want 1 00000100", imem_req, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_alu_branch();
        int cyc; logic srw, sdw, wrw, stk; logic [31:0] wld;
        // ADDI x1, x0, 5
        exec_instr(32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 0, 0, 32'h0,
                   cyc, srw, sdw, wrw, wld, stk);
        total_cnt++;
        if (stk || cyc != 4) $display("FAIL addi_cycles: got %0d stuck %b want 4", cyc, stk);
        else pass_cnt++;
        total_cnt++;
        if (wrw !== 1'b1 || ir !== 32'h0050_0093)
            $display("FAIL addi_wb: reg_we %b ir %h want 1 00500093", wrw, ir);
        else pass_cnt++;
        total_cnt++;
        if (pc !== 32'h104 || imem_addr !== 32'h104)
            $display("FAIL addi_pc: pc %h addr %h want 00000104", pc, imem_addr);
        else pass_cnt++;
        // BEQ x0, x0 taken
        exec_instr(32'h0000_0063, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 0, 0, 32'h0,
                   cyc, srw, sdw, wrw, wld, stk);
        total_cnt++;
        if (stk || cyc != 4) $display("FAIL br_cycles: got %0d stuck %b want 4", cyc, stk);
        else pass_cnt++;
        total_cnt++;
        if (srw !== 1'b0) $display("FAIL br_reg_we: got %b want 0", srw);
        else pass_cnt++;
        total_cnt++;
        if (pc !== 32'h80 || instret !== 32'd2)
            $display("FAIL br_retire: pc %h instret %0d want 00000080 2", pc, instret);
        else pass_cnt++;
    endtask

    task automatic test_load();
        int cyc; logic srw, sdw, wrw, stk; logic [31:0] wld;
        exec_instr(32'h0000_2103, 1'b1, 1'b0, 1'b0, 1'b1, 32'h84, 0, 3, 32'hDEAD_BEEF,
                   cyc, srw, sdw, wrw, wld, stk);
        total_cnt++;
        if (stk || cyc != 8) $display("FAIL load_cycles: got %0d stuck %b want 8", cyc, stk);
        else pass_cnt++;
        total_cnt++;
        if (sdw !== 1'b0) $display("FAIL load_dmem_we: got %b want 0", sdw);
        else pass_cnt++;
        total_cnt++;
        if (wld !== 32'hDEAD_BEEF || wrw !== 1'b1)
            $display("FAIL load_wb: data %h reg_we %b want deadbeef 1", wld, wrw);
        else pass_cnt++;
        total_cnt++;
        if (pc !== 32'h84 || instret !== 32'd3)
            $display("FAIL load_retire: pc %h instret %0d want 00000084 3", pc, instret);
        else pass_cnt++;
    endtask

    task automatic test_store();
        int cyc; logic srw, sdw, wrw, stk; logic [31:0] wld;
        exec_instr(32'h0020_a023, 1'b0, 1'b1, 1'b0, 1'b0, 32'h88, 0, 0, 32'h1234_5678,
                   cyc, srw, sdw, wrw, wld, stk);
        total_cnt++;
        if (stk || cyc != 5) $display("FAIL store_cycles: got %0d stuck %b want 5", cyc, stk);
        else pass_cnt++;
        total_cnt++;
        if (sdw !== 1'b1 || srw !== 1'b0)
            $display("FAIL store_strobes: dmem_we %b reg_we %b want 1 0", sdw, srw);
        else pass_cnt++;
        total_cnt++;
        if (load_data !== 32'hDEAD_BEEF)
            $display("FAIL store_load_data: got %h want deadbeef", load_data);
        else pass_cnt++;
        total_cnt++;
        if (instret !== 32'd4) $display("FAIL store_instret: got %0d want 4", instret);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cyc; logic srw, sdw, wrw, stk; logic [31:0] wld;
        exec_instr(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1000, 0, 32'h0,
                   cyc, srw, sdw, wrw, wld, stk);
        total_cnt++;
        if (stk || cyc != 16) $display("FAIL to_cycles: got %0d stuck %b want 16", cyc, stk);
        else pass_cnt++;
        total_cnt++;
        if (bus_err !== 1'b1 || halted !== 1'b1 || state !== 3'd5)
            $display("FAIL to_trap: err %b halted %b state %0d want 1 1 5",
                     bus_err, halted, state);
        else pass_cnt++;
        total_cnt++;
        if (pc !== 32'h88 || ir !== 32'h0020_a023 || instret !== 32'd4)
            $display("FAIL to_regs: pc %h ir %h instret %0d want 00000088 0020a023 4",
                     pc, ir, instret);
        else pass_cnt++;
        // Acks in TRAP must not wake the core.
        imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick(); tick(); tick();
        total_cnt++;
        if (state !== 3'd5 || imem_req !== 1'b0 || dmem_req !== 1'b0 || ir !== 32'h0020_a023)
            $display("FAIL trap_sticky: state %0d ireq %b dreq %b ir %h want 5 0 0 0020a023",
                     state, imem_req, dmem_req, ir);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (bus_err !== 1'b0 || state !== 3'd0)
            $display("FAIL to_reset: err %b state %0d want 0 0", bus_err, state);
        else pass_cnt++;
        // Ack arriving in the 16th wait cycle wins over the timeout.
        exec_instr(32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 15, 0, 32'h0,
                   cyc, srw, sdw, wrw, wld, stk);
        total_cnt++;
        if (stk || cyc != 19 || bus_err !== 1'b0)
            $display("FAIL to_ack16: cycles %0d stuck %b err %b want 19 0 0", cyc, stk, bus_err);
        else pass_cnt++;
        total_cnt++;
        if (pc !== 32'h104 || instret !== 32'd1)
            $display("FAIL to_ack16_retire: pc %h instret %0d want 00000104 1", pc, instret);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int cyc; logic srw, sdw, wrw, stk; logic [31:0] wld;
        exec_instr(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 0, 0, 32'h0,
                   cyc, srw, sdw, wrw, wld, stk);
        total_cnt++;
        if (stk || cyc != 2 || state !== 3'd5)
            $display("FAIL ill_trap: cycles %0d state %0d stuck %b want 2 5 0", cyc, state, stk);
        else pass_cnt++;
        total_cnt++;
        if (instret !== 32'd1 || halted !== 1'b1 || bus_err !== 1'b0 || srw !== 1'b0)
            $display("FAIL ill_regs: instret %0d halted %b err %b rwe %b want 1 1 0 0",
                     instret, halted, bus_err, srw);
        else pass_cnt++;
    endtask

    task automatic test_mem_reset();
        do_reset();
        imem_rdata = 32'h0000_2103; imem_ack = 1'b1; op_load = 1'b1; wreg = 1'b1;
        next_pc = 32'h500;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0)
            $display("FAIL mr_mem: state %0d dreq %b dwe %b want 3 1 0", state, dmem_req, dmem_we);
        else pass_cnt++;
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        total_cnt++;
        if (state !== 3'd3 || ir !== 32'h0000_2103)
            $display("FAIL mr_stray_ack: state %0d ir %h want 3 00002103", state, ir);
        else pass_cnt++;
        imem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (state !== 3'd0 || pc !== 32'h100 || bus_err !== 1'b0)
            $display("FAIL mr_reset: state %0d pc %h err %b want 0 00000100 0", state, pc, bus_err);
        else pass_cnt++;
        total_cnt++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || ir !== 32'h13 || instret !== 32'd0)
            $display("FAIL mr_reset_out: dreq %b ireq %b ir %h instret %0d want 0 0 00000013 0",
                     dmem_req, imem_req, ir, instret);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_alu_branch();
        test_load();
        test_store();
        test_timeout();
        test_illegal();
        test_mem_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
